// File: rtl/arm_pkg.sv
// Shared encodings for the instruction loader: immediate formats, loader states
// and bit positions of the instruction fields in the encoded word.
package arm_pkg;

  localparam logic [1:0] IMM_DP8   = 2'b00;
  localparam logic [1:0] IMM_MEM12 = 2'b01;
  localparam logic [1:0] IMM_BR24  = 2'b10;
  localparam logic [1:0] IMM_BAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    WR,
    DONE
  } loader_state_t;

  localparam int COND_LSB     = 28;
  localparam int OP_LSB       = 26;
  localparam int FUNCT_LSB    = 20;
  localparam int BR_FUNCT_LSB = 24;
  localparam int RN_LSB       = 16;
  localparam int RD_LSB       = 12;

endpackage

// File: rtl/imm_compress.sv
// Inverse of the immediate extender: packs a 32-bit immediate into its
// instruction field and flags values the chosen format cannot represent.
module imm_compress
  import arm_pkg::*;
(
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Imm,
  output logic [23:0] field,
  output logic        legal
);

  always_comb begin
    field = '0;
    legal = 1'b0;
    case (ImmSrc)
      IMM_DP8: begin
        field = {16'b0, Imm[7:0]};
        legal = (Imm[31:8] == 24'b0);
      end
      IMM_MEM12: begin
        field = {12'b0, Imm[11:0]};
        legal = (Imm[31:12] == 20'b0);
      end
      IMM_BR24: begin
        // word offset must be aligned and its sign must fit in 26 bits
        field = Imm[25:2];
        legal = (Imm[1:0] == 2'b00) &&
                ((Imm[31:25] == 7'h00) || (Imm[31:25] == 7'h7F));
      end
      IMM_BAD: begin
        field = '0;
        legal = 1'b0;
      end
      default: begin
        field = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Accepts instruction field sets, encodes them and writes the legal ones to
// consecutive instruction-memory words, flagging range/format errors.
//   state | meaning
//   IDLE  | ready for the next field set
//   ENC   | fields registered, encoding and range check in progress
//   WR    | write the encoded word if it is legal, advance the address
//   DONE  | program loaded or memory full; held until reset
module instr_loader
  import arm_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Imm,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        done,
  output logic        full
);

  localparam logic [31:0] LAST_ADDR = 32'((MEM_WORDS - 1) * 4);

  loader_state_t state, state_nxt;

  logic [3:0]  cond_q, rn_q, rd_q;
  logic [1:0]  op_q, immsrc_q;
  logic [5:0]  funct_q;
  logic [31:0] imm_q;
  logic        last_q;
  logic [31:0] word_q, enc_word, addr;
  logic        legal_q;
  logic [23:0] imm_field;
  logic        imm_legal;
  logic        last_slot;

  imm_compress u_imm_compress (
    .ImmSrc (immsrc_q),
    .Imm    (imm_q),
    .field  (imm_field),
    .legal  (imm_legal)
  );

  always_comb begin
    enc_word = '0;
    enc_word[COND_LSB +: 4] = cond_q;
    enc_word[OP_LSB +: 2]   = op_q;
    if (immsrc_q == IMM_BR24) begin
      enc_word[BR_FUNCT_LSB +: 2] = funct_q[5:4];
      enc_word[23:0]              = imm_field;
    end else begin
      enc_word[FUNCT_LSB +: 6] = funct_q;
      enc_word[RN_LSB +: 4]    = rn_q;
      enc_word[RD_LSB +: 4]    = rd_q;
      enc_word[11:0]           = imm_field[11:0];
    end
  end

  assign last_slot = (addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // reset gates the handshake and the write strobe so an aborted word never lands
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset;
        if (in_valid) state_nxt = ENC;
      end
      ENC: state_nxt = WR;
      WR: begin
        imem_we = legal_q & reset;
        if (last_q)                      state_nxt = DONE;
        else if (legal_q && last_slot)   state_nxt = DONE;
        else                             state_nxt = IDLE;
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cond_q   <= '0;
      op_q     <= '0;
      funct_q  <= '0;
      rn_q     <= '0;
      rd_q     <= '0;
      immsrc_q <= '0;
      imm_q    <= '0;
      last_q   <= 1'b0;
      word_q   <= '0;
      legal_q  <= 1'b0;
      addr     <= '0;
      err      <= 1'b0;
      err_addr <= '0;
      full     <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        cond_q   <= Cond;
        op_q     <= Op;
        funct_q  <= Funct;
        rn_q     <= Rn;
        rd_q     <= Rd;
        immsrc_q <= ImmSrc;
        imm_q    <= Imm;
        last_q   <= in_last;
      end
      if (state == ENC) begin
        word_q  <= enc_word;
        legal_q <= imm_legal;
      end
      if (state == WR) begin
        if (legal_q) begin
          addr <= addr + 32'd4;
          if (!last_q && last_slot) full <= 1'b1;
        end else begin
          err <= 1'b1;
          if (!err) err_addr <= addr;
        end
      end
    end
  end

  assign imem_addr = addr;
  assign imem_wd   = word_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The module SHALL have the port `clk`, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The module SHALL have the port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-003 The module SHALL have the port `in_valid`, input, 1 bit: an instruction field set is present.
REQ-004 The module SHALL have the port `in_ready`, output, 1 bit: the loader accepts a field set this cycle.
REQ-005 The module SHALL have the port `in_last`, input, 1 bit: the field set is the final instruction of the program.
REQ-006 The module SHALL have the ports `Cond` (input, 4 bits: condition field), `Op` (input, 2 bits: opcode), `Funct` (input, 6 bits: function field), `Rn` (input, 4 bits: first source register) and `Rd` (input, 4 bits: destination register).
REQ-007 The module SHALL have the port `ImmSrc`, input, 2 bits: immediate format (00 data-processing imm8, 01 LDR/STR imm12, 10 branch imm24, 11 illegal).
REQ-008 The module SHALL have the port `Imm`, input, 32 bits: the full-width immediate value to compress.
REQ-009 The module SHALL have the ports `imem_we` (output, 1 bit: instruction-memory write strobe), `imem_addr` (output, 32 bits: byte address of the write) and `imem_wd` (output, 32 bits: encoded instruction word).
REQ-010 The module SHALL have the ports `err` (output, 1 bit: sticky range/format error), `err_addr` (output, 32 bits: address at the first error), `done` (output, 1 bit: program fully loaded) and `full` (output, 1 bit: memory capacity reached).
REQ-011 The module SHALL have the parameter `MEM_WORDS`, default 64: instruction memory capacity in words.

Function
REQ-012 The FSM SHALL have the states IDLE, ENC, WR and DONE; `in_ready` SHALL be 1 only in IDLE.
REQ-013 On IDLE with in_valid=1, the module SHALL register all field inputs and in_last, then go to ENC.
REQ-014 ENC SHALL register the encoded word and the range-check result, then go to WR.
REQ-015 WR SHALL assert imem_we=1 for exactly one cycle only if the range check passed, i.e. at accept cycle n+2.
REQ-016 Word layout for ImmSrc 00 and 01 SHALL be {Cond, Op, Funct, Rn, Rd, Src12}.
REQ-017 For ImmSrc 00, Src12 SHALL be {4'b0000, Imm[7:0]}, and the value is legal only if Imm[31:8]==0.
REQ-018 For ImmSrc 01, Src12 SHALL be Imm[11:0], and the value is legal only if Imm[31:12]==0.
REQ-019 For ImmSrc 10, the word SHALL be {Cond, Op, Funct[5:4], Imm[25:2]}, and the value is legal only if Imm[1:0]==0 and Imm[31:25] are all equal (sign fits in 26 bits).
REQ-020 ImmSrc 11 SHALL always be illegal.
REQ-021 On a legal word in WR: imem_addr SHALL equal the internal address, and the address SHALL increment by 4 after the write.
REQ-022 On an illegal word in WR: no write; the address SHALL NOT increment; err SHALL be set to 1. On the first error only, err_addr SHALL capture the current address.
REQ-023 After WR: if in_last=1 (legal or not), go to DONE.
REQ-024 After WR: else if the write just made was word MEM_WORDS-1, set full=1 and go to DONE.
REQ-025 After WR: otherwise return to IDLE.
REQ-026 DONE SHALL hold done=1 and in_ready=0 until reset; there is no address wrap-around.
REQ-027 in_valid while in_ready=0 SHALL be ignored; the source holds its fields until the handshake.
REQ-028 imem_wd SHALL be valid whenever imem_we=1; its value is don't-care otherwise.

Reset
REQ-029 When reset=0 at a clock edge, the module SHALL go to IDLE and clear the address, imem_we, err, err_addr, done and full to 0.
REQ-030 A reset in ENC or WR SHALL abort the in-flight word: no write in the same or the following cycle.
REQ-031 Reset SHALL take priority over every other event.

Structure
REQ-032 The shared package arm_pkg SHALL hold the ImmSrc encodings (IMM_DP8, IMM_MEM12, IMM_BR24), the loader state enum and the instruction field-position constants.
REQ-033 The design SHALL have exactly one combinational sub-module, imm_compress (inputs ImmSrc and Imm; outputs a 24-bit field and a legal flag), which is the inverse of the immediate extender.

Verification
REQ-034 The bench SHALL check: reset, then one ImmSrc=00 field set with Cond=E, Op=00, Funct=101000, Rn=1, Rd=2, Imm=0x7F, in_last=1 -> imem_we at n+2, addr 0x0, wd 0xE282107F, then done=1.
REQ-035 The bench SHALL check: ImmSrc=01 with Imm=0xFFF, then ImmSrc=01 with Imm=0x1000 -> first write at addr 0; second is not written; err=1, err_addr=0x4.
REQ-036 The bench SHALL check: ImmSrc=10, Cond=E, Op=10, Funct=10xxxx, Imm=0xFFFFFFF8 -> wd 0xEAFFFFFE; Imm=0x6 -> illegal, err=1.
REQ-037 The bench SHALL check: MEM_WORDS=4 with 5 legal field sets offered back-to-back -> writes to 0x0, 0x4, 0x8, 0xC; full=1, done=1; fifth never accepted (in_ready=0).
REQ-038 The bench SHALL check: reset=0 asserted during ENC -> no imem_we pulse; next accepted word written at addr 0.
REQ-039 The bench SHALL check: in_valid held high continuously -> in_ready=1 once every 3 cycles; fields captured only on the handshake.
